// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, state encoding and helpers for the DM arbiter
package dm_pkg;

  localparam logic [2:0] SIZE_NONE = 3'd0;
  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  localparam int PORT_MEM = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Only byte, half and word accesses exist on the DM.
  function automatic logic size_ok(input logic [2:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD);
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - selects the low bytes of a DM word and zero/sign extends them
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] ext_o
);

  // Byte and half loads replicate their top bit only when a signed load is requested.
  always_comb begin
    ext_o = word_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{24{sign_i & word_i[7]}}, word_i[7:0]};
      SIZE_HALF: ext_o = {{16{sign_i & word_i[15]}}, word_i[15:0]};
      SIZE_WORD: ext_o = word_i;
      default:   ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin two-port arbiter with lock for the single-port data memory
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LOCK_MAX      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [1:0]  req_signed,
  input  logic [1:0]  req_lock,
  input  logic [5:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data_in,
  output logic [2:0]  dm_size,
  input  logic [31:0] dm_data_out
);

  localparam int              CW        = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0]   IDLE_LAST = CW'(LOCK_MAX - 1);
  localparam logic [32:0]     MEM_BYTES = 33'd1 << ADDRESS_WIDTH;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic [1:0]    ready;
  logic          accept;
  logic          sel;
  logic          sel_we;
  logic          sel_signed;
  logic          sel_lock;
  logic [2:0]    sel_size;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [32:0]   end_addr;
  logic          legal;
  logic          do_write;
  logic [31:0]   load_val;

  // Grant: owner only while locked, otherwise round-robin with the last winner losing ties.
  // Nothing is granted while reset is held so no transfer can slip in.
  always_comb begin
    ready = 2'b00;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid == 2'b11) ready[~last_grant_q] = 1'b1;
          else                    ready = req_valid;
        end
        ST_OWN0: ready[PORT_MEM] = 1'b1;
        ST_OWN1: ready[PORT_DBG] = 1'b1;
        default: ready = 2'b00;
      endcase
    end
  end

  // Mux the granted port's request fields and judge legality without address wrap.
  always_comb begin
    accept     = |(ready & req_valid);
    sel        = ready[PORT_DBG];
    sel_we     = sel ? req_we[1]         : req_we[0];
    sel_signed = sel ? req_signed[1]     : req_signed[0];
    sel_lock   = sel ? req_lock[1]       : req_lock[0];
    sel_size   = sel ? req_size[5:3]     : req_size[2:0];
    sel_addr   = sel ? req_addr[63:32]   : req_addr[31:0];
    sel_wdata  = sel ? req_wdata[63:32]  : req_wdata[31:0];
    end_addr   = {1'b0, sel_addr} + {30'b0, sel_size};
    legal      = size_ok(sel_size) && (end_addr <= MEM_BYTES);
    do_write   = accept && sel_we && legal;
  end

  dm_load_ext u_load_ext (
    .word_i (dm_data_out),
    .size_i (sel_size),
    .sign_i (sel_signed),
    .ext_o  (load_val)
  );

  // DM is driven only in the accept cycle; loads present the address with size 0.
  always_comb begin
    dm_address = accept   ? sel_addr  : 32'd0;
    dm_data_in = do_write ? sel_wdata : 32'd0;
    dm_size    = do_write ? sel_size  : SIZE_NONE;
  end

  // Ownership, round-robin pointer and the watchdog that frees a stalled lock.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = idle_cnt_q;
    if (accept) begin
      last_grant_d = sel;
      idle_cnt_d   = '0;
      if (sel_lock) state_d = sel ? ST_OWN1 : ST_OWN0;
      else          state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      // Owner is always ready, so no accept here means the owner is not requesting.
      if (idle_cnt_q == IDLE_LAST) begin
        state_d    = ST_IDLE;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + CW'(1);
      end
    end
  end

  // Response for an accept is captured at the end of its cycle and shown for one cycle.
  always_comb begin
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    if (accept) begin
      rsp_valid_d = sel ? 2'b10 : 2'b01;
      rsp_err_d   = ~legal;
      rsp_rdata_d = (legal && !sel_we) ? load_val : 32'd0;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      idle_cnt_q   <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // A response pending when reset arrives is dropped rather than shown.
  always_comb begin
    req_ready = ready;
    rsp_valid = reset ? 2'b00 : rsp_valid_q;
    rsp_err   = reset ? 1'b0  : rsp_err_q;
    rsp_rdata = reset ? 32'd0 : rsp_rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized and directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

  localparam int LOCK_MAX = 16;
  localparam int MEM_SZ   = 1024;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_we, req_signed, req_lock;
  logic [5:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata, dm_address, dm_data_in, dm_data_out;
  logic [2:0]  dm_size;

  dm_arbiter #(.ADDRESS_WIDTH(10), .LOCK_MAX(LOCK_MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_signed  (req_signed),
    .req_lock    (req_lock),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_rdata   (rsp_rdata),
    .dm_address  (dm_address),
    .dm_data_in  (dm_data_in),
    .dm_size     (dm_size),
    .dm_data_out (dm_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the DUT: writes at posedge, combinational read of 4 bytes.
  logic [7:0]  dm_mem [0:MEM_SZ-1];
  logic [32:0] rd_a;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MEM_SZ; k++) dm_mem[k] <= 8'h00;
    end else if (dm_size != 3'd0) begin
      for (int k = 0; k < int'(dm_size); k++)
        dm_mem[10'(dm_address + 32'(k))] <= dm_data_in[8*k +: 8];
    end
  end

  always_comb begin
    dm_data_out = 32'd0;
    rd_a        = 33'd0;
    for (int k = 0; k < 4; k++) begin
      rd_a = {1'b0, dm_address} + 33'(k);
      dm_data_out[8*k +: 8] = (rd_a < 33'(MEM_SZ)) ? dm_mem[rd_a[9:0]] : 8'h00;
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:MEM_SZ-1];
  int          m_owner;
  int          m_last;
  int          m_idle;
  logic [1:0]  pend_valid;
  logic        pend_err;
  logic [31:0] pend_rdata;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic we, input logic sg,
                          input logic lk, input logic [2:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_signed[p]         = sg;
    req_lock[p]           = lk;
    req_size[p*3 +: 3]    = sz;
    req_addr[p*32 +: 32]  = ad;
    req_wdata[p*32 +: 32] = wd;
  endtask

  // One cycle: inputs already applied after negedge; check, advance model, move to next negedge.
  task automatic step();
    logic [1:0]  exp_ready, acc;
    int          p;
    logic [2:0]  sz;
    logic [31:0] ad, wd, val;
    logic        legal;
    #1;
    check("rsp_valid", 32'(rsp_valid), reset ? 32'd0 : 32'(pend_valid));
    check("rsp_err",   32'(rsp_err),   reset ? 32'd0 : 32'(pend_err));
    check("rsp_rdata", rsp_rdata,      reset ? 32'd0 : pend_rdata);
    if (reset)                  exp_ready = 2'b00;
    else if (m_owner >= 0)      exp_ready = 2'b01 << m_owner;
    else if (req_valid == 2'b11) exp_ready = (m_last == 0) ? 2'b10 : 2'b01;
    else                        exp_ready = req_valid;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    acc        = req_valid & exp_ready;
    pend_valid = 2'b00;
    pend_err   = 1'b0;
    pend_rdata = 32'd0;
    if (reset) begin
      check("dm_size_rst", 32'(dm_size), 32'd0);
      m_owner = -1;
      m_last  = 1;
      m_idle  = 0;
      for (int k = 0; k < MEM_SZ; k++) ref_mem[k] = 8'h00;
    end else if (acc != 2'b00) begin
      p     = acc[1] ? 1 : 0;
      sz    = req_size[p*3 +: 3];
      ad    = req_addr[p*32 +: 32];
      wd    = req_wdata[p*32 +: 32];
      legal = (sz == 3'd1 || sz == 3'd2 || sz == 3'd4) &&
              (longint'(ad) + longint'(sz) <= longint'(MEM_SZ));
      if (req_we[p] && legal) begin
        check("dm_size",    32'(dm_size), 32'(sz));
        check("dm_address", dm_address, ad);
        check("dm_data_in", dm_data_in, wd);
        for (int k = 0; k < int'(sz); k++) ref_mem[int'(ad) + k] = wd[8*k +: 8];
      end else begin
        check("dm_size_nowr", 32'(dm_size), 32'd0);
      end
      if (legal && !req_we[p]) begin
        val = 32'd0;
        for (int k = 0; k < int'(sz); k++) val = val | (32'(ref_mem[int'(ad) + k]) << (8*k));
        if (req_signed[p] && sz != 3'd4 && val[8*int'(sz)-1])
          val = val | (32'hFFFF_FFFF << (8*int'(sz)));
        pend_rdata = val;
      end
      pend_valid = 2'b01 << p;
      pend_err   = ~legal;
      m_last     = p;
      m_owner    = req_lock[p] ? p : -1;
      m_idle     = 0;
    end else begin
      check("dm_size_idle", 32'(dm_size), 32'd0);
      if (m_owner >= 0) begin
        m_idle++;
        if (m_idle == LOCK_MAX) begin
          m_owner = -1;
          m_idle  = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] size_tab [0:7];
  logic [31:0] ra;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_owner = -1; m_last = 1; m_idle = 0;
    pend_valid = 2'b00; pend_err = 1'b0; pend_rdata = 32'd0;
    for (int k = 0; k < MEM_SZ; k++) ref_mem[k] = 8'h00;
    size_tab[0] = 3'd1; size_tab[1] = 3'd2; size_tab[2] = 3'd4; size_tab[3] = 3'd1;
    size_tab[4] = 3'd2; size_tab[5] = 3'd4; size_tab[6] = 3'd3; size_tab[7] = 3'd0;
    reset = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_signed = 2'b00; req_lock = 2'b00;
    req_size = 6'd0; req_addr = 64'd0; req_wdata = 64'd0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // 1: both valid from reset; port0 store wins, port1 load next, sees new data
    set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h10, 32'hDEAD_BEEF);
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h10, 32'h0);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h10, 32'h0);
    step();
    check("t1_rsp_port1", 32'(rsp_valid), 32'h2);
    check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h0, 32'h0);

    // 2: byte store then signed and unsigned byte loads
    set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h21, 32'h0000_0080);
    step();
    set_port(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'h21, 32'h0);
    step();
    check("t2_lb", rsp_rdata, 32'hFFFF_FF80);
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h21, 32'h0);
    step();
    check("t2_lbu", rsp_rdata, 32'h0000_0080);

    // 3: port1 holds a lock while port0 keeps requesting
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h40, 32'h0);
    step();
    set_port(1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'h40, 32'h1234_5678);
    step();
    #1 check("t3_locked", 32'(req_ready), 32'h2);
    step();
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h40, 32'h0);
    step();
    set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h0, 32'h0);
    #1 check("t3_port0_next", 32'(req_ready), 32'h1);
    step();

    // 4: locked owner goes quiet; watchdog frees the memory after LOCK_MAX idle cycles
    set_port(1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 32'h10, 32'h0);
    step();
    set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h0, 32'h0);
    for (int i = 0; i < LOCK_MAX; i++) begin
      #1 check("t4_stall", 32'(req_ready[0]), 32'd0);
      step();
    end
    #1 check("t4_release", 32'(req_ready), 32'h1);
    step();

    // 5: illegal accesses at the top boundary and with a bad size
    set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h3FE, 32'hAABB_CCDD);
    step();
    check("t5_err_bound", 32'(rsp_err), 32'd1);
    check("t5_rdata_bound", rsp_rdata, 32'd0);
    set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 32'h10, 32'h1111_1111);
    step();
    check("t5_err_size", 32'(rsp_err), 32'd1);
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h3FE, 32'h0);
    step();
    check("t5_top_half_ok", 32'(rsp_err), 32'd0);
    check("t5_top_unchanged", rsp_rdata, 32'd0);
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h10, 32'h0);
    step();
    check("t5_mem_unchanged", rsp_rdata, 32'hDEAD_BEEF);

    // 6: reset the cycle after a load accept drops its response
    set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 32'h10, 32'h0);
    step();
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 32'h0, 32'h0);
    step();
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rdata", rsp_rdata, 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 9))
          0:       ra = $urandom();
          1, 2:    ra = 32'h3F8 + 32'($urandom_range(0, 7));
          default: ra = 32'($urandom_range(0, 15));
        endcase
        set_port(p, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 size_tab[$urandom_range(0, 7)], ra, $urandom());
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
